r2n_buffer: RTL and testbench



---
 rtl/r2n_pkg.sv | 42 ++++
 rtl/r2n_lane_scatter.sv | 37 +++
 rtl/r2n_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_r2n_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r2n_pkg.sv
// Shared types and size helpers for the ready-to-normal buffer.
// Sizes derive from BLOCK_SIZE, NUM_CORES, ROW and COL; num_cores() is the mapping also used by n2r_buffer_v2.
package r2n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } r2n_state_e;

    function automatic int num_cores(input int col);
        case (col)
            2754:    return 9;
            256:     return 8;
            200:     return 5;
            64:      return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int slice_rows(input int block_size, input int cores);
        return block_size * cores;
    endfunction

    function automatic int chunks_per_row(input int col, input int block_size);
        return col / block_size;
    endfunction

    function automatic int num_slices(input int row, input int srows);
        return (row + srows - 1) / srows;
    endfunction

    // Rows actually present in the final slice; 1..srows.
    function automatic int last_rows(input int row, input int srows);
        return row - (num_slices(row, srows) - 1) * srows;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/r2n_lane_scatter.sv
// Write path of the slice buffer: splits one chunk word into per-row lanes
// and selects the column chunk they land in.
module r2n_lane_scatter
    import r2n_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BLOCK_SIZE     = 2,
    parameter int SLICE_ROWS     = 16,
    parameter int CHUNKS_PER_ROW = 128
) (
    input  logic                                              wr_stb,
    input  logic [cnt_width(CHUNKS_PER_ROW)-1:0]              chunk_cnt,
    input  logic [SLICE_ROWS*BLOCK_SIZE*WIDTH-1:0]            in_word,
    output logic [SLICE_ROWS-1:0]                             wr_en,
    output logic [CHUNKS_PER_ROW-1:0]                         wr_chunk_sel,
    output logic [SLICE_ROWS-1:0][BLOCK_SIZE*WIDTH-1:0]       wr_data
);

    localparam int LANE_W = BLOCK_SIZE * WIDTH;
    localparam int IN_W   = SLICE_ROWS * LANE_W;
    localparam int CNT_W  = cnt_width(CHUNKS_PER_ROW);

    // Every lane of an accepted word carries a row, so all rows write together.
    always_comb begin
        wr_en        = '0;
        wr_chunk_sel = '0;
        wr_data      = '0;
        for (int i = 0; i < SLICE_ROWS; i++) begin
            wr_en[i]   = wr_stb;
            wr_data[i] = in_word[IN_W-1-i*LANE_W -: LANE_W];
        end
        for (int k = 0; k < CHUNKS_PER_ROW; k++) begin
            wr_chunk_sel[k] = wr_stb && (chunk_cnt == CNT_W'(k));
        end
    end

endmodule

// File: rtl/r2n_buffer.sv
// Reassembles column-chunked matmul output words into full row-major rows.
// Optional macro R2N_LAST_EN adds out_last, flagging the final row of the matrix.
module r2n_buffer
    import r2n_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int ROW        = 2754,
    parameter int COL        = 256,
    parameter int NUM_CORES  = num_cores(COL)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  in_r2n_buffer,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH*COL-1:0]                   out_r2n_buffer,
    output logic                                   slice_done,
    output logic                                   matrix_done,
    output r2n_state_e                             state_dbg
`ifdef R2N_LAST_EN
    ,
    output logic                                   out_last
`endif
);

    localparam int SR       = slice_rows(BLOCK_SIZE, NUM_CORES);
    localparam int CPR      = chunks_per_row(COL, BLOCK_SIZE);
    localparam int NS       = num_slices(ROW, SR);
    localparam int LR       = last_rows(ROW, SR);
    localparam int CHUNK_CW = cnt_width(CPR);
    localparam int SLICE_CW = cnt_width(NS);
    localparam int ROW_CW   = cnt_width(SR);
    localparam int LANE_W   = WIDTH * BLOCK_SIZE;

    if (COL % BLOCK_SIZE != 0) begin : g_col_check
        $error("r2n_buffer: COL must be a multiple of BLOCK_SIZE");
    end
    if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chunk_check
        $error("r2n_buffer: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
    end
    if (FRAC_WIDTH > WIDTH) begin : g_frac_check
        $error("r2n_buffer: FRAC_WIDTH must not exceed WIDTH");
    end

    // Handshake: a word moves on in_valid && in_ready, a row moves on out_valid && out_ready;
    // the presented row and out_valid never change while out_valid && !out_ready.

    r2n_state_e                  state_q, state_d;
    logic [CHUNK_CW-1:0]         chunk_cnt_q, chunk_cnt_d;
    logic [SLICE_CW-1:0]         slice_cnt_q, slice_cnt_d;
    logic [ROW_CW-1:0]           row_cnt_q, row_cnt_d;
    logic                        out_valid_q, out_valid_d;
    logic [WIDTH*COL-1:0]        out_data_q, out_data_d;

    // Chunk 0 sits at the MSB end of each row so a row reads out with column 0 first.
    logic [SR-1:0][0:CPR-1][LANE_W-1:0] buf_q, buf_d;

    logic                        accept;
    logic                        final_slice;
    logic [ROW_CW-1:0]           last_row;
    logic                        load;
    logic [ROW_CW-1:0]           load_idx;
    logic                        slice_pulse;
    logic                        matrix_pulse;

    logic [SR-1:0]               wr_en;
    logic [CPR-1:0]              wr_chunk_sel;
    logic [SR-1:0][LANE_W-1:0]   wr_data;

    assign in_ready    = (state_q == ST_COLLECT);
    assign accept      = in_ready && in_valid;
    assign final_slice = (slice_cnt_q == SLICE_CW'(NS - 1));
    assign last_row    = final_slice ? ROW_CW'(LR - 1) : ROW_CW'(SR - 1);

    r2n_lane_scatter #(
        .WIDTH          (WIDTH),
        .BLOCK_SIZE     (BLOCK_SIZE),
        .SLICE_ROWS     (SR),
        .CHUNKS_PER_ROW (CPR)
    ) u_scatter (
        .wr_stb       (accept),
        .chunk_cnt    (chunk_cnt_q),
        .in_word      (in_r2n_buffer),
        .wr_en        (wr_en),
        .wr_chunk_sel (wr_chunk_sel),
        .wr_data      (wr_data)
    );

    always_comb begin
        buf_d = buf_q;
        for (int r = 0; r < SR; r++) begin
            for (int k = 0; k < CPR; k++) begin
                if (wr_en[r] && wr_chunk_sel[k]) begin
                    buf_d[r][k] = wr_data[r];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        chunk_cnt_d  = chunk_cnt_q;
        slice_cnt_d  = slice_cnt_q;
        row_cnt_d    = row_cnt_q;
        out_valid_d  = out_valid_q;
        load         = 1'b0;
        load_idx     = '0;
        slice_pulse  = 1'b0;
        matrix_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (chunk_cnt_q == CHUNK_CW'(CPR - 1)) begin
                        chunk_cnt_d = '0;
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b1;
                        load        = 1'b1;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + CHUNK_CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (row_cnt_q == last_row) begin
                        slice_pulse = 1'b1;
                        row_cnt_d   = '0;
                        out_valid_d = 1'b0;
                        if (final_slice) begin
                            matrix_pulse = 1'b1;
                            slice_cnt_d  = '0;
                            state_d      = ST_IDLE;
                        end else begin
                            slice_cnt_d = slice_cnt_q + SLICE_CW'(1);
                            state_d     = ST_COLLECT;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_CW'(1);
                        load      = 1'b1;
                        load_idx  = row_cnt_q + ROW_CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reading from buf_d lets row 0 go out the cycle after the last chunk lands.
    always_comb begin
        out_data_d = load ? buf_d[load_idx] : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chunk_cnt_q <= '0;
            slice_cnt_q <= '0;
            row_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            slice_cnt_q <= slice_cnt_d;
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid      = out_valid_q;
    assign out_r2n_buffer = out_data_q;
    assign slice_done     = slice_pulse && !rst;
    assign matrix_done    = matrix_pulse && !rst;
    assign state_dbg      = state_q;

`ifdef R2N_LAST_EN
    logic out_last_q, out_last_d;

    always_comb begin
        if (load) begin
            out_last_d = final_slice && (load_idx == ROW_CW'(LR - 1));
        end else begin
            out_last_d = out_last_q && out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_last_q <= 1'b0;
        end else begin
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

endmodule

// File: tb/tb_r2n_buffer.sv
// Self-checking bench for r2n_buffer on a 6x8 matrix with 2 cores (4-row slices).
module tb_r2n_buffer;
    import r2n_pkg::*;

    localparam int W   = 16;
    localparam int BS  = 2;
    localparam int CS  = 4;
    localparam int NC  = 2;
    localparam int COL = 8;
    localparam int ROW = 6;
    localparam int SR  = 4;
    localparam int CPR = 4;
    localparam int NS  = 2;
    localparam int LR  = 2;
    localparam int RW  = W * COL;
    localparam int IW  = W * CS * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_word;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic          slice_done;
    logic          matrix_done;
    r2n_state_e    state_dbg;
`ifdef R2N_LAST_EN
    logic          out_last;
`endif

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] exp_q[$];
    logic [1:0]    exp_flag_q[$];

    always #5 clk = ~clk;

    r2n_buffer #(
        .WIDTH      (W),
        .FRAC_WIDTH (8),
        .BLOCK_SIZE (BS),
        .CHUNK_SIZE (CS),
        .ROW        (ROW),
        .COL        (COL),
        .NUM_CORES  (NC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_r2n_buffer  (in_word),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_r2n_buffer (out_row),
        .slice_done     (slice_done),
        .matrix_done    (matrix_done),
        .state_dbg      (state_dbg)
`ifdef R2N_LAST_EN
        ,
        .out_last       (out_last)
`endif
    );

    function automatic logic [RW-1:0] exp_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int c = 0; c < COL; c++) v[RW-1-c*W -: W] = W'((r << 8) | c);
        return v;
    endfunction

    // Lane i carries slice row i; rows past the matrix end carry junk.
    function automatic logic [IW-1:0] mk_word(input int s, input int k);
        logic [IW-1:0] v;
        int r;
        v = '0;
        for (int i = 0; i < SR; i++) begin
            r = s * SR + i;
            for (int j = 0; j < BS; j++) begin
                v[IW-1-(i*BS+j)*W -: W] = (r < ROW) ? W'((r << 8) | (k * BS + j)) : 16'hFFFF;
            end
        end
        return v;
    endfunction

    task automatic push_slice(input int s);
        int  rows;
        logic last;
        rows = (s == NS - 1) ? LR : SR;
        for (int i = 0; i < rows; i++) begin
            last = (i == rows - 1);
            exp_q.push_back(exp_row(s * SR + i));
            exp_flag_q.push_back({last, last && (s == NS - 1)});
        end
    endtask

    // Scoreboard: every row handshake pops one expected row and its pulse flags.
    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_row;
    logic [RW-1:0] sb_row;
    logic [1:0]    sb_flag;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== prev_row) begin
                    errors++;
                    $display("FAIL hold: valid=%b row=%h, required valid=1 row=%h", out_valid, out_row, prev_row);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_row: got %h, required no row", out_row);
                end else begin
                    sb_row  = exp_q.pop_front();
                    sb_flag = exp_flag_q.pop_front();
                    if (out_row !== sb_row) begin
                        errors++;
                        $display("FAIL row_data: got %h, required %h", out_row, sb_row);
                    end
                    checks++;
                    if ({slice_done, matrix_done} !== sb_flag) begin
                        errors++;
                        $display("FAIL row_pulses: got slice_done,matrix_done=%b%b, required %b", slice_done, matrix_done, sb_flag);
                    end
`ifdef R2N_LAST_EN
                    checks++;
                    if (out_last !== sb_flag[0]) begin
                        errors++;
                        $display("FAIL out_last: got %b, required %b", out_last, sb_flag[0]);
                    end
`endif
                end
            end else begin
                checks++;
                if (slice_done !== 1'b0 || matrix_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_pulse: got slice_done,matrix_done=%b%b, required 00", slice_done, matrix_done);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_row   = out_row;
        end
    end

    // Driver tasks enter and leave 1 time unit after a rising edge.
    task automatic start_matrix();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic send_word(input logic [IW-1:0] w);
        logic acc;
        int   n;
        in_word  = w;
        in_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
    endtask

    task automatic send_slice(input int s, input int max_gap);
        for (int k = 0; k < CPR; k++) begin
            send_word(mk_word(s, k));
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d rows outstanding, required 0", exp_q.size());
            exp_q.delete();
            exp_flag_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks += 6;
        if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        if (out_row !== '0)       begin errors++; $display("FAIL reset_out_row: got %h, required 0", out_row); end
        if (in_ready !== 1'b0)    begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        if (slice_done !== 1'b0)  begin errors++; $display("FAIL reset_slice_done: got %b, required 0", slice_done); end
        if (matrix_done !== 1'b0) begin errors++; $display("FAIL reset_matrix_done: got %b, required 0", matrix_done); end
        if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b, required 0", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_slice();
        start_matrix();
        push_slice(0);
        for (int k = 0; k < CPR - 1; k++) send_word(mk_word(0, k));
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1;
        send_word(mk_word(0, CPR - 1));
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_row_latency: out_valid=%b, required 1", out_valid); end
        if (in_ready !== 1'b0)  begin errors++; $display("FAIL drain_in_ready: got %b, required 0", in_ready); end
        for (int i = 1; i < SR; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_row%0d: out_valid=%b, required 1", i, out_valid); end
        end
        @(negedge clk);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL after_slice_valid: got %b, required 0", out_valid); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL after_slice_in_ready: got %b, required 1", in_ready); end
        if (state_dbg !== ST_COLLECT) begin errors++; $display("FAIL after_slice_state: got %0d, required %0d", state_dbg, ST_COLLECT); end
        @(posedge clk); #1;
        wait_empty(20);
    endtask

    task automatic test_partial_slice();
        push_slice(1);
        send_slice(1, 0);
        wait_empty(20);
        repeat (3) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== 1'b0)    begin errors++; $display("FAIL extra_rows: out_valid=%b, required 0", out_valid); end
            if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL end_state: got %0d, required %0d", state_dbg, ST_IDLE); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        start_matrix();
        push_slice(0);
        send_slice(0, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1)       begin errors++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
            if (out_row !== exp_row(1))   begin errors++; $display("FAIL stall_row: got %h, required %h", out_row, exp_row(1)); end
            if (in_ready !== 1'b0)        begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_empty(20);
        push_slice(1);
        send_slice(1, 1);
        wait_empty(20);
    endtask

    task automatic test_input_gaps();
        start_matrix();
        push_slice(0);
        for (int k = 0; k < CPR; k++) begin
            send_word(mk_word(0, k));
            if (k < CPR - 1) begin
                repeat (2) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_word  = {(IW/32){32'hDEADBEEF}};
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_ignore: in_ready=%b, required 0", in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_empty(20);
        push_slice(1);
        send_slice(1, 2);
        wait_empty(20);
    endtask

    task automatic test_reset_mid_collect();
        start_matrix();
        send_word(mk_word(0, 0));
        send_word(mk_word(0, 1));
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
        if (out_row !== '0)        begin errors++; $display("FAIL midrst_row: got %h, required 0", out_row); end
        if (in_ready !== 1'b0)     begin errors++; $display("FAIL midrst_in_ready: got %b, required 0", in_ready); end
        if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d, required %0d", state_dbg, ST_IDLE); end
        @(posedge clk); #1;
        rst = 1'b0;
        start_matrix();
        push_slice(0);
        push_slice(1);
        send_slice(0, 0);
        send_slice(1, 0);
        wait_empty(40);
    endtask

    task automatic test_random_ready();
        logic stop;
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join_none
        start_matrix();
        push_slice(0);
        push_slice(1);
        send_slice(0, 2);
        send_slice(1, 2);
        wait_empty(400);
        stop = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_full_slice();
        test_partial_slice();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_collect();
        test_random_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
